l2_axi_rd_ctrl: RTL and testbench
=================================

// Module: l2_axi_rd_ctrl
// PURPOSE
// - AXI4 read-channel front end of the L2 memory, between the partition AXI cut and the SRAM bank arbiter.
// - Accepts one AR burst at a time and expands it into per-beat line-read requests (FIXED/INCR/WRAP).
// - Buffers in-order memory read data and returns it on the R channel with ID, RLAST and RRESP.
// - Credit-based issue: R backpressure never drops memory data.
// PARAMETERS
// - ID_W       4    AXI ID width
// - ADDR_W     40   AXI byte-address width
// - DATA_W     512  AXI/SRAM line width in bits (power of 2, >=64)
// - RSP_DEPTH  4    beats in flight (issued, not yet returned on R); >=2
// PORTS
// - i_clk              in   1             L2 partition clock
// - i_rst_n            in   1             synchronous reset, active low
// - i_axi_s_arvalid    in   1             AR valid
// - o_axi_s_arready    out  1             AR ready
// - i_axi_s_arid       in   ID_W          AR ID
// - i_axi_s_araddr     in   ADDR_W        AR byte address
// - i_axi_s_arlen      in   8             AR beats-1
// - i_axi_s_arsize     in   3             AR log2(bytes/beat)
// - i_axi_s_arburst    in   2             AR burst type
// - o_axi_s_rvalid     out  1             R valid
// - i_axi_s_rready     in   1             R ready
// - o_axi_s_rid        out  ID_W          R ID
// - o_axi_s_rdata      out  DATA_W        R data
// - o_axi_s_rresp      out  2             R response
// - o_axi_s_rlast      out  1             R last
// - o_mem_req_valid    out  1             line-read request valid
// - i_mem_req_ready    in   1             request accepted by bank arbiter
// - o_mem_req_addr     out  ADDR_W-LB     line address, LB=$clog2(DATA_W/8)
// - i_mem_rsp_valid    in   1             read data valid, in request order, any latency
// - i_mem_rsp_data     in   DATA_W        read data
// - i_mem_rsp_err      in   1             uncorrectable error on this line
// BEHAVIOUR
// - One clock (i_clk); reset is synchronous and active-low (i_rst_n); no async paths.
// - Reset: arready=0, rvalid=0, mem_req_valid=0, rid/rdata/rresp/rlast=0.
//   FSM=IDLE, credits=RSP_DEPTH, both FIFOs empty.
// - Reset mid-burst: same values on the next edge; in-flight memory responses are discarded
//   (memory shares this reset).
// - FSM IDLE: registered arready=1 (first cycle is the one after reset release).
//   AR handshake latches id/addr/len/size/burst, clears beat_cnt, goes to BURST, drops arready.
// - FSM BURST: one beat issued per cycle when credits>0:
//   - Legal burst: mem_req_valid=1, addr=beat_addr>>LB; issue on mem_req_ready.
//   - Illegal burst: no memory request; meta-only beat pushed.
//   - Every issue pushes meta {id, last=(beat_cnt==len), has_data, err} and decrements credits.
// - Last beat issued -> IDLE; arready=1 the following cycle (one-cycle bubble between bursts).
// - Address: FIXED keeps addr. INCR: addr+=1<<size, modulo 2^ADDR_W, no 4KB check.
//   WRAP: wrap window=(len+1)<<size, aligned down; addr wraps to window base.
//   Narrow sizes allowed; consecutive beats in one line re-read that line.
// - Illegal: burst==2'b11, WRAP with len not in {1,3,7,15}, or size>LB.
//   Return len+1 beats, rresp=SLVERR, rdata=0, no memory access.
// - Data FIFO (RSP_DEPTH) written on mem_rsp_valid. Overflow is impossible by credits.
// - R valid = meta FIFO non-empty & (!head.has_data | data FIFO non-empty); rvalid held until rready.
//   rresp = SLVERR if head.err or data err, else OKAY.
// - R handshake pops meta (and data if has_data) and increments credits.
// - Issue and R handshake in the same cycle: credits unchanged.
// - Full throughput (1 beat/cycle) requires RSP_DEPTH >= memory latency+1.
// - Credits=0: mem_req_valid=0; the FSM holds without losing beat state.
// STRUCTURE
// - l2_p_pkg: l2_rd_meta_t {id,last,has_data,err}, axi burst localparams, LB derivation.
// - Sub-module l2_axi_beat_addr (combinational next-address for FIXED/INCR/WRAP + legality flag).
// - Two instances of the common-library synchronous FIFO (meta, data); FSM and credit counter local.
// TESTING
// - INCR len=3 size=6 addr=0x1000 id=5:
//   mem addrs 0x40,0x41,0x42,0x43; 4 R beats rid=5 OKAY, rlast on beat 4 only.
// - WRAP len=3 size=6 addr=0x10C0: mem addrs 0x43,0x40,0x41,0x42; rlast on beat 4.
// - INCR size=3 len=15 addr=0x0: 16 beats; line 0x0 for beats 0-7, 0x1 for beats 8-15.
// - rready=0, len=7, memory latency 2: exactly 4 mem reqs, then mem_req_valid=0.
//   rready=1: remaining 4 issued, 8 beats in order, no loss or duplication.
// - burst=2'b11 len=1: no mem_req_valid; 2 beats SLVERR rdata=0 rlast on beat 2.
//   WRAP len=2: 3 SLVERR beats.
//   mem_rsp_err on beat 1 of an INCR len=1: beat 1 SLVERR, beat 2 OKAY.
// - i_rst_n=0 for 1 cycle after 2 of 8 beats issued: all valids 0 next edge, credits=4.
//   arready=1 cycle after release; new INCR len=0 completes normally.

Source files
------------

// File: rtl/l2_axi_rd_ctrl_pkg.sv
// Shared types and constants for the L2 AXI read front end: burst/response encodings,
// beat metadata carried from issue to the R channel, and FSM state encoding.
package l2_axi_rd_ctrl_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
  localparam logic [1:0] AXI_BURST_RSVD  = 2'b11;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Width of the id field carried in beat metadata; the top's ID_W must match.
  localparam int L2_ID_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } l2_rd_state_e;

  typedef struct packed {
    logic [L2_ID_W-1:0] id;
    logic               last;
    logic               has_data;
    logic               err;
  } l2_rd_meta_t;

  function automatic int l2_line_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/l2_axi_rd_ctrl_if.sv
// AXI read-channel and SRAM line-read bundles. Handshake rule for every channel: a transfer
// happens on a rising edge where valid and ready are both 1; valid never waits on ready.
interface l2_axi_rd_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 40,
  parameter int DATA_W = 512
);
  logic              i_axi_s_arvalid;
  logic              o_axi_s_arready;
  logic [ID_W-1:0]   i_axi_s_arid;
  logic [ADDR_W-1:0] i_axi_s_araddr;
  logic [7:0]        i_axi_s_arlen;
  logic [2:0]        i_axi_s_arsize;
  logic [1:0]        i_axi_s_arburst;
  logic              o_axi_s_rvalid;
  logic              i_axi_s_rready;
  logic [ID_W-1:0]   o_axi_s_rid;
  logic [DATA_W-1:0] o_axi_s_rdata;
  logic [1:0]        o_axi_s_rresp;
  logic              o_axi_s_rlast;

  modport slave (
    input  i_axi_s_arvalid, i_axi_s_arid, i_axi_s_araddr, i_axi_s_arlen,
           i_axi_s_arsize, i_axi_s_arburst, i_axi_s_rready,
    output o_axi_s_arready, o_axi_s_rvalid, o_axi_s_rid, o_axi_s_rdata,
           o_axi_s_rresp, o_axi_s_rlast
  );

  modport master (
    output i_axi_s_arvalid, i_axi_s_arid, i_axi_s_araddr, i_axi_s_arlen,
           i_axi_s_arsize, i_axi_s_arburst, i_axi_s_rready,
    input  o_axi_s_arready, o_axi_s_rvalid, o_axi_s_rid, o_axi_s_rdata,
           o_axi_s_rresp, o_axi_s_rlast
  );
endinterface

interface l2_mem_rd_if #(
  parameter int ADDR_W = 40,
  parameter int DATA_W = 512
);
  localparam int LB = $clog2(DATA_W / 8);

  logic                 o_mem_req_valid;
  logic                 i_mem_req_ready;
  logic [ADDR_W-LB-1:0] o_mem_req_addr;
  logic                 i_mem_rsp_valid;
  logic [DATA_W-1:0]    i_mem_rsp_data;
  logic                 i_mem_rsp_err;

  modport master (
    output o_mem_req_valid, o_mem_req_addr,
    input  i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data, i_mem_rsp_err
  );

  modport slave (
    input  o_mem_req_valid, o_mem_req_addr,
    output i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data, i_mem_rsp_err
  );
endinterface

// File: rtl/l2_axi_rd_ctrl_beat_addr.sv
// Next-beat address for FIXED/INCR/WRAP bursts and the legality flag for a latched AR.
module l2_axi_beat_addr
  import l2_axi_rd_ctrl_pkg::*;
#(
  parameter int ADDR_W = 40,
  parameter int LB     = 6
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        len_i,
  input  logic [2:0]        size_i,
  input  logic [1:0]        burst_i,
  output logic [ADDR_W-1:0] next_addr_o,
  output logic              legal_o
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] wrap_mask;
  logic              wrap_len_ok;

  always_comb begin
    step        = ADDR_W'(1) << size_i;
    incr        = addr_i + step;
    wrap_mask   = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);
    wrap_len_ok = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);
    legal_o     = (burst_i != AXI_BURST_RSVD) && (int'(size_i) <= LB) &&
                  ((burst_i != AXI_BURST_WRAP) || wrap_len_ok);
    // Window size is a power of two for legal WRAP, so the carry out of the mask drops away.
    unique case (burst_i)
      AXI_BURST_FIXED: next_addr_o = addr_i;
      AXI_BURST_INCR:  next_addr_o = incr;
      AXI_BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (incr & wrap_mask);
      default:         next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/l2_axi_rd_ctrl_fifo.sv
// Synchronous first-word-fall-through FIFO; pushes when full and pops when empty are ignored.
module l2_axi_rd_ctrl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push_i && (cnt_q != CNT_W'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);
  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/l2_axi_rd_ctrl.sv
// AXI4 read front end of the L2: expands one AR burst at a time into line reads and returns
// in-order data on R. Issue is credit-limited so R backpressure can never drop memory data.
module l2_axi_rd_ctrl
  import l2_axi_rd_ctrl_pkg::*;
#(
  parameter int ID_W      = L2_ID_W,
  parameter int ADDR_W    = 40,
  parameter int DATA_W    = 512,
  parameter int RSP_DEPTH = 4,
  localparam int LB       = l2_line_bits(DATA_W),
  localparam int CRED_W   = $clog2(RSP_DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  l2_axi_rd_if.slave         axi_s,
  l2_mem_rd_if.master        mem,
  output l2_rd_state_e       o_dbg_state,
  output logic [CRED_W-1:0]  o_dbg_credits
);

  l2_rd_state_e      state_q;
  logic              arready_q;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [7:0]        beat_cnt_q;
  logic [CRED_W-1:0] credits_q;

  logic [ADDR_W-1:0] next_addr;
  logic              legal;
  logic              have_credit, issue, rvalid, r_hs;
  l2_rd_meta_t       meta_wdata, meta_head;
  logic              meta_empty, data_empty;
  logic [DATA_W:0]   data_head;

  l2_axi_beat_addr #(.ADDR_W(ADDR_W), .LB(LB)) u_beat_addr (
    .addr_i     (addr_q),
    .len_i      (len_q),
    .size_i     (size_q),
    .burst_i    (burst_q),
    .next_addr_o(next_addr),
    .legal_o    (legal)
  );

  // Illegal bursts still occupy credits so their SLVERR beats obey the same in-flight bound.
  assign have_credit = (state_q == ST_BURST) && (credits_q != '0);
  assign issue       = have_credit && (!legal || mem.i_mem_req_ready);

  assign mem.o_mem_req_valid = have_credit && legal;
  assign mem.o_mem_req_addr  = addr_q[ADDR_W-1:LB];

  always_comb begin
    meta_wdata          = '0;
    meta_wdata.id       = id_q;
    meta_wdata.last     = (beat_cnt_q == len_q);
    meta_wdata.has_data = legal;
    meta_wdata.err      = !legal;
  end

  l2_axi_rd_ctrl_fifo #(.WIDTH($bits(l2_rd_meta_t)), .DEPTH(RSP_DEPTH)) u_meta_fifo (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .push_i (issue),
    .wdata_i(meta_wdata),
    .pop_i  (r_hs),
    .rdata_o(meta_head),
    .empty_o(meta_empty)
  );

  l2_axi_rd_ctrl_fifo #(.WIDTH(DATA_W + 1), .DEPTH(RSP_DEPTH)) u_data_fifo (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .push_i (mem.i_mem_rsp_valid),
    .wdata_i({mem.i_mem_rsp_err, mem.i_mem_rsp_data}),
    .pop_i  (r_hs && meta_head.has_data),
    .rdata_o(data_head),
    .empty_o(data_empty)
  );

  assign rvalid = !meta_empty && (!meta_head.has_data || !data_empty);
  assign r_hs   = rvalid && axi_s.i_axi_s_rready;

  assign axi_s.o_axi_s_arready = arready_q;
  assign axi_s.o_axi_s_rvalid  = rvalid;
  assign axi_s.o_axi_s_rid     = rvalid ? meta_head.id : '0;
  assign axi_s.o_axi_s_rlast   = rvalid && meta_head.last;
  assign axi_s.o_axi_s_rdata   = (rvalid && meta_head.has_data) ? data_head[DATA_W-1:0] : '0;
  assign axi_s.o_axi_s_rresp   =
    (rvalid && (meta_head.err || (meta_head.has_data && data_head[DATA_W]))) ?
    AXI_RESP_SLVERR : AXI_RESP_OKAY;

  assign o_dbg_state   = state_q;
  assign o_dbg_credits = credits_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      arready_q  <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      beat_cnt_q <= '0;
      credits_q  <= CRED_W'(RSP_DEPTH);
    end else begin
      if (issue && !r_hs)      credits_q <= credits_q - CRED_W'(1);
      else if (!issue && r_hs) credits_q <= credits_q + CRED_W'(1);

      unique case (state_q)
        ST_IDLE: begin
          if (arready_q && axi_s.i_axi_s_arvalid) begin
            id_q       <= axi_s.i_axi_s_arid;
            addr_q     <= axi_s.i_axi_s_araddr;
            len_q      <= axi_s.i_axi_s_arlen;
            size_q     <= axi_s.i_axi_s_arsize;
            burst_q    <= axi_s.i_axi_s_arburst;
            beat_cnt_q <= '0;
            arready_q  <= 1'b0;
            state_q    <= ST_BURST;
          end else begin
            arready_q  <= 1'b1;
          end
        end
        ST_BURST: begin
          if (issue) begin
            addr_q     <= next_addr;
            beat_cnt_q <= beat_cnt_q + 8'd1;
            if (beat_cnt_q == len_q) state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_axi_rd_ctrl.sv
// Bench for l2_axi_rd_ctrl: directed bursts plus random traffic against a beat-list model.
`timescale 1ns/1ps
module tb_l2_axi_rd_ctrl;
  import l2_axi_rd_ctrl_pkg::*;

  localparam int ID_W      = 4;
  localparam int ADDR_W    = 40;
  localparam int DATA_W    = 512;
  localparam int RSP_DEPTH = 4;
  localparam int LB        = 6;
  localparam int LINE_W    = ADDR_W - LB;
  localparam int CRED_W    = 3;
  localparam int EXP_W     = ID_W + 2 + 1 + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  l2_axi_rd_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();
  l2_mem_rd_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem ();
  l2_rd_state_e      dbg_state;
  logic [CRED_W-1:0] dbg_credits;

  l2_axi_rd_ctrl #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RSP_DEPTH(RSP_DEPTH)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .axi_s        (axi.slave),
    .mem          (mem.master),
    .o_dbg_state  (dbg_state),
    .o_dbg_credits(dbg_credits)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [EXP_W-1:0]  exp_q[$];
  logic [LINE_W-1:0] exp_addr_q[$];
  logic [LINE_W-1:0] rsp_line_q[$];
  int                rsp_due_q[$];
  int mem_lat = 1;
  int req_ready_pct = 100;
  int rready_pct = 100;
  bit err_en = 1'b0;
  logic [LINE_W-1:0] err_line = '0;
  int mem_hs_cnt = 0;
  int mem_valid_cycles = 0;
  int r_beats = 0;

  function automatic logic [DATA_W-1:0] mem_data(input logic [LINE_W-1:0] line);
    logic [DATA_W-1:0] d;
    for (int k = 0; k < DATA_W / 32; k++)
      d[k*32 +: 32] = (line[31:0] * 32'h9E37_79B1) + 32'h1234_0000 + 32'(k);
    return d;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: list every beat of a burst from the AXI address rules.
  task automatic model_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                          input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    bit legal;
    logic [ADDR_W-1:0] a, base, win, bytes;
    logic [LINE_W-1:0] line;
    logic [DATA_W-1:0] d;
    logic [1:0] resp;
    legal = (burst != 2'b11) && (int'(size) <= LB) &&
            !(burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    bytes = ADDR_W'(1) << size;
    win   = ADDR_W'(int'(len) + 1) * bytes;
    base  = addr - (addr % win);
    for (int i = 0; i <= int'(len); i++) begin
      if (legal) begin
        if (burst == 2'b00)      a = addr;
        else if (burst == 2'b01) a = addr + ADDR_W'(i) * bytes;
        else                     a = base + ((addr - base + ADDR_W'(i) * bytes) % win);
        line = a[ADDR_W-1:LB];
        exp_addr_q.push_back(line);
        d    = mem_data(line);
        resp = (err_en && line == err_line) ? 2'b10 : 2'b00;
      end else begin
        d    = '0;
        resp = 2'b10;
      end
      exp_q.push_back({id, resp, (i == int'(len)), d});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    bit done = 1'b0;
    model_ar(id, addr, len, size, burst);
    axi.i_axi_s_arvalid = 1'b1;
    axi.i_axi_s_arid    = id;
    axi.i_axi_s_araddr  = addr;
    axi.i_axi_s_arlen   = len;
    axi.i_axi_s_arsize  = size;
    axi.i_axi_s_arburst = burst;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      if (axi.o_axi_s_arready) done = 1'b1;
    end
    @(posedge clk);
    #2;
    axi.i_axi_s_arvalid = 1'b0;
    check("ar_accepted", 64'(done), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || exp_addr_q.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(posedge clk);
    #2;
    check("drain_outstanding", 64'(exp_q.size() + exp_addr_q.size()), 64'd0);
  endtask

  // ---------------- memory responder and ready drivers ----------------
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      mem.i_mem_rsp_valid = 1'b0;
      mem.i_mem_rsp_data  = '0;
      mem.i_mem_rsp_err   = 1'b0;
      rsp_line_q.delete();
      rsp_due_q.delete();
    end else if (rsp_line_q.size() != 0 && rsp_due_q[0] <= cycle) begin
      mem.i_mem_rsp_valid = 1'b1;
      mem.i_mem_rsp_data  = mem_data(rsp_line_q[0]);
      mem.i_mem_rsp_err   = err_en && (rsp_line_q[0] == err_line);
      void'(rsp_line_q.pop_front());
      void'(rsp_due_q.pop_front());
    end else begin
      mem.i_mem_rsp_valid = 1'b0;
      mem.i_mem_rsp_data  = '0;
      mem.i_mem_rsp_err   = 1'b0;
    end
    mem.i_mem_req_ready = ($urandom_range(99) < req_ready_pct);
    axi.i_axi_s_rready  = ($urandom_range(99) < rready_pct);
  end

  // ---------------- monitor ----------------
  logic [EXP_W-1:0]  mon_got, mon_exp;
  logic [LINE_W-1:0] mon_line;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem.o_mem_req_valid) mem_valid_cycles++;
      if (mem.o_mem_req_valid && mem.i_mem_req_ready) begin
        mem_hs_cnt++;
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mem_req_unexpected actual=0x%0h expected=none", mem.o_mem_req_addr);
        end else begin
          mon_line = exp_addr_q.pop_front();
          check("mem_req_addr", 64'(mem.o_mem_req_addr), 64'(mon_line));
        end
        rsp_line_q.push_back(mem.o_mem_req_addr);
        rsp_due_q.push_back(cycle + mem_lat);
      end
      if (axi.o_axi_s_rvalid && axi.i_axi_s_rready) begin
        r_beats++;
        mon_got = {axi.o_axi_s_rid, axi.o_axi_s_rresp, axi.o_axi_s_rlast, axi.o_axi_s_rdata};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL r_beat_unexpected actual id=%0h resp=%0h last=%0b expected=none",
                   axi.o_axi_s_rid, axi.o_axi_s_rresp, axi.o_axi_s_rlast);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            failures++;
            $display("FAIL r_beat actual id=%0h resp=%0h last=%0b data=%h expected id=%0h resp=%0h last=%0b data=%h",
                     mon_got[EXP_W-1 -: ID_W], mon_got[DATA_W+2 -: 2], mon_got[DATA_W],
                     mon_got[DATA_W-1:0], mon_exp[EXP_W-1 -: ID_W], mon_exp[DATA_W+2 -: 2],
                     mon_exp[DATA_W], mon_exp[DATA_W-1:0]);
          end
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  int hs0, v0, b0, k;
  logic [1:0] rb;
  logic [7:0] rl;
  logic [2:0] rs;
  logic [ADDR_W-1:0] ra;
  initial begin
    axi.i_axi_s_arvalid = 1'b0;
    axi.i_axi_s_arid    = '0;
    axi.i_axi_s_araddr  = '0;
    axi.i_axi_s_arlen   = '0;
    axi.i_axi_s_arsize  = '0;
    axi.i_axi_s_arburst = '0;
    axi.i_axi_s_rready  = 1'b0;
    mem.i_mem_req_ready = 1'b0;
    mem.i_mem_rsp_valid = 1'b0;
    mem.i_mem_rsp_data  = '0;
    mem.i_mem_rsp_err   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_arready", 64'(axi.o_axi_s_arready), 64'd0);
    check("rst_rvalid", 64'(axi.o_axi_s_rvalid), 64'd0);
    check("rst_mem_req_valid", 64'(mem.o_mem_req_valid), 64'd0);
    check("rst_rid", 64'(axi.o_axi_s_rid), 64'd0);
    check("rst_rdata_nonzero", 64'(axi.o_axi_s_rdata != '0), 64'd0);
    check("rst_rresp", 64'(axi.o_axi_s_rresp), 64'd0);
    check("rst_rlast", 64'(axi.o_axi_s_rlast), 64'd0);
    check("rst_credits", 64'(dbg_credits), 64'd4);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("arready_after_rst", 64'(axi.o_axi_s_arready), 64'd1);

    mem_lat = 2;
    b0 = r_beats;
    send_ar(4'd5, 40'h1000, 8'd3, 3'd6, 2'b01);
    wait_idle(500);
    check("incr_beats", 64'(r_beats - b0), 64'd4);
    send_ar(4'd3, 40'h10C0, 8'd3, 3'd6, 2'b10);
    wait_idle(500);
    b0 = r_beats;
    send_ar(4'd7, 40'h0, 8'd15, 3'd3, 2'b01);
    wait_idle(500);
    check("narrow_beats", 64'(r_beats - b0), 64'd16);

    // R stalled: issue must stop once all credits are out
    rready_pct = 0;
    hs0 = mem_hs_cnt;
    send_ar(4'd2, 40'h2000, 8'd7, 3'd6, 2'b01);
    repeat (20) @(posedge clk);
    #2;
    check("stall_reqs", 64'(mem_hs_cnt - hs0), 64'd4);
    check("stall_req_valid", 64'(mem.o_mem_req_valid), 64'd0);
    check("stall_credits", 64'(dbg_credits), 64'd0);
    check("stall_state", 64'(dbg_state), 64'(ST_BURST));
    rready_pct = 100;
    wait_idle(500);
    check("stall_total_reqs", 64'(mem_hs_cnt - hs0), 64'd8);

    v0 = mem_valid_cycles;
    send_ar(4'd9, 40'h3000, 8'd1, 3'd6, 2'b11);
    wait_idle(500);
    send_ar(4'd10, 40'h3040, 8'd2, 3'd6, 2'b10);
    wait_idle(500);
    send_ar(4'd11, 40'h3080, 8'd0, 3'd7, 2'b01);
    wait_idle(500);
    check("illegal_no_mem_valid", 64'(mem_valid_cycles - v0), 64'd0);

    err_en = 1'b1;
    err_line = LINE_W'(40'h4000 >> LB);
    send_ar(4'd12, 40'h4000, 8'd1, 3'd6, 2'b01);
    wait_idle(500);
    err_en = 1'b0;

    // reset in the middle of a stalled burst
    rready_pct = 0;
    hs0 = mem_hs_cnt;
    send_ar(4'd4, 40'h5000, 8'd7, 3'd6, 2'b01);
    k = 0;
    while (mem_hs_cnt - hs0 < 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("pre_reset_reqs", 64'(mem_hs_cnt - hs0), 64'd2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    check("midrst_rvalid", 64'(axi.o_axi_s_rvalid), 64'd0);
    check("midrst_mem_req_valid", 64'(mem.o_mem_req_valid), 64'd0);
    check("midrst_arready", 64'(axi.o_axi_s_arready), 64'd0);
    check("midrst_credits", 64'(dbg_credits), 64'd4);
    check("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
    exp_q.delete();
    exp_addr_q.delete();
    rst_n = 1'b1;
    rready_pct = 100;
    @(posedge clk);
    #2;
    check("midrst_arready_release", 64'(axi.o_axi_s_arready), 64'd1);
    b0 = r_beats;
    send_ar(4'd1, 40'h6000, 8'd0, 3'd6, 2'b01);
    wait_idle(500);
    check("post_rst_beats", 64'(r_beats - b0), 64'd1);

    // random back-to-back traffic
    for (int n = 0; n < 40; n++) begin
      rready_pct    = ($urandom_range(2) == 0) ? 30 : 100;
      req_ready_pct = ($urandom_range(1) == 0) ? 60 : 100;
      mem_lat       = $urandom_range(4, 1);
      k = $urandom_range(9);
      rb = (k < 4) ? 2'b01 : (k < 7) ? 2'b10 : (k < 8) ? 2'b00 : 2'b11;
      rs = ($urandom_range(7) == 0) ? 3'd7 : 3'($urandom_range(6));
      if (rb == 2'b10 && $urandom_range(4) != 0) rl = 8'((2 << $urandom_range(3)) - 1);
      else rl = 8'($urandom_range(15));
      ra = {$urandom, $urandom};
      if ($urandom_range(7) == 0) ra = {ADDR_W{1'b1}} - ADDR_W'($urandom_range(255));
      send_ar(4'($urandom_range(15)), ra, rl, rs, rb);
    end
    rready_pct = 100;
    req_ready_pct = 100;
    wait_idle(5000);
    check("final_credits", 64'(dbg_credits), 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
